// File: rtl/access_splitter.sv
// Splits CPU word/dword accesses into little-endian hword beats for the 16-bit bottleneck
// and reassembles read beats into one 64-bit result with a single ack.
module access_splitter #(
    parameter int ADR_WIDTH = 64
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [ADR_WIDTH-1:0] m_adr_i,
    input  logic                 m_cyc_i,
    input  logic                 m_stb_i,
    input  logic                 m_we_i,
    input  logic [1:0]           m_siz_i,
    input  logic                 m_signed_i,
    input  logic [63:0]          m_dat_i,
    output logic                 m_ack_o,
    output logic [63:0]          m_dat_o,
    output logic                 m_err_align_o,
    output logic [ADR_WIDTH-1:0] s_adr_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    output logic                 s_we_o,
    output logic [1:0]           s_siz_o,
    output logic                 s_signed_o,
    output logic [63:0]          s_dat_o,
    input  logic                 s_ack_i,
    input  logic [63:0]          s_dat_i
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BEAT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [1:0]           last_q, last_d;
    logic [1:0]           siz_q, siz_d;
    logic                 we_q, we_d;
    logic                 sgn_q, sgn_d;
    logic [ADR_WIDTH-1:0] base_q, base_d;
    logic [63:0]          dat_q, dat_d;
    logic [63:0]          acc_q, acc_d;
    logic                 m_ack_q, m_ack_d;
    logic [63:0]          m_dat_q, m_dat_d;
    logic [ADR_WIDTH-1:0] s_adr_q, s_adr_d;
    logic                 s_cyc_q, s_cyc_d;
    logic                 s_we_q, s_we_d;
    logic [1:0]           s_siz_q, s_siz_d;
    logic                 s_signed_q, s_signed_d;
    logic [63:0]          s_dat_q, s_dat_d;
    logic                 misaligned;

    // Beat payload: byte lane only for byte accesses, otherwise the hword slice for this beat.
    function automatic logic [15:0] beat_dat(input logic [63:0] d, input logic [1:0] siz,
                                             input logic [1:0] c);
        if (siz == 2'b00) return {8'h00, d[7:0]};
        return d[{c, 4'b0000} +: 16];
    endfunction

    always_comb begin
        misaligned = 1'b0;
        case (m_siz_i)
            2'b01:   misaligned = m_adr_i[0];
            2'b10:   misaligned = |m_adr_i[1:0];
            2'b11:   misaligned = |m_adr_i[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign m_err_align_o = m_cyc_i & m_stb_i & misaligned;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        siz_d      = siz_q;
        we_d       = we_q;
        sgn_d      = sgn_q;
        base_d     = base_q;
        dat_d      = dat_q;
        acc_d      = acc_q;
        m_ack_d    = 1'b0;
        m_dat_d    = m_dat_q;
        s_adr_d    = s_adr_q;
        s_cyc_d    = 1'b0;
        s_we_d     = s_we_q;
        s_siz_d    = s_siz_q;
        s_signed_d = s_signed_q;
        s_dat_d    = s_dat_q;
        case (state_q)
            IDLE: begin
                if (m_cyc_i && m_stb_i && !misaligned) begin
                    state_d    = BEAT;
                    base_d     = m_adr_i;
                    siz_d      = m_siz_i;
                    we_d       = m_we_i;
                    sgn_d      = m_signed_i;
                    dat_d      = m_dat_i;
                    cnt_d      = 2'd0;
                    last_d     = (m_siz_i == 2'b11) ? 2'd3 : (m_siz_i == 2'b10) ? 2'd1 : 2'd0;
                    acc_d      = 64'h0;
                    s_cyc_d    = 1'b1;
                    s_adr_d    = m_adr_i;
                    s_we_d     = m_we_i;
                    s_siz_d    = m_siz_i[1] ? 2'b01 : m_siz_i;
                    s_signed_d = m_siz_i[1] ? 1'b0 : m_signed_i;
                    s_dat_d    = {48'h0, beat_dat(m_dat_i, m_siz_i, 2'd0)};
                end
            end
            BEAT: begin
                if (!m_cyc_i) begin
                    // Abort wins over a coincident slave ack.
                    state_d = IDLE;
                    acc_d   = 64'h0;
                end else begin
                    s_cyc_d = 1'b1;
                    if (s_ack_i) begin
                        if (!siz_q[1]) acc_d = s_dat_i;
                        else           acc_d[{cnt_q, 4'b0000} +: 16] = s_dat_i[15:0];
                        if (cnt_q == last_q) begin
                            state_d = DONE;
                            s_cyc_d = 1'b0;
                        end else begin
                            cnt_d   = cnt_q + 2'd1;
                            s_adr_d = base_q + ADR_WIDTH'({cnt_d, 1'b0});
                            s_dat_d = {48'h0, beat_dat(dat_q, siz_q, cnt_d)};
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                m_ack_d = 1'b1;
                if (!we_q) begin
                    if (siz_q == 2'b10)
                        m_dat_d = {sgn_q ? {32{acc_q[31]}} : 32'h0, acc_q[31:0]};
                    else
                        m_dat_d = acc_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            last_q     <= 2'd0;
            siz_q      <= 2'd0;
            we_q       <= 1'b0;
            sgn_q      <= 1'b0;
            base_q     <= '0;
            dat_q      <= 64'h0;
            acc_q      <= 64'h0;
            m_ack_q    <= 1'b0;
            m_dat_q    <= 64'h0;
            s_adr_q    <= '0;
            s_cyc_q    <= 1'b0;
            s_we_q     <= 1'b0;
            s_siz_q    <= 2'd0;
            s_signed_q <= 1'b0;
            s_dat_q    <= 64'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            siz_q      <= siz_d;
            we_q       <= we_d;
            sgn_q      <= sgn_d;
            base_q     <= base_d;
            dat_q      <= dat_d;
            acc_q      <= acc_d;
            m_ack_q    <= m_ack_d;
            m_dat_q    <= m_dat_d;
            s_adr_q    <= s_adr_d;
            s_cyc_q    <= s_cyc_d;
            s_we_q     <= s_we_d;
            s_siz_q    <= s_siz_d;
            s_signed_q <= s_signed_d;
            s_dat_q    <= s_dat_d;
        end
    end

    assign m_ack_o    = m_ack_q;
    assign m_dat_o    = m_dat_q;
    assign s_adr_o    = s_adr_q;
    assign s_cyc_o    = s_cyc_q;
    assign s_stb_o    = s_cyc_q;
    assign s_we_o     = s_we_q;
    assign s_siz_o    = s_siz_q;
    assign s_signed_o = s_signed_q;
    assign s_dat_o    = s_dat_q;
endmodule
